l0_pool_rd: RTL and testbench
=============================

// Module: l0_pool_rd
// PURPOSE
//  Read-side sequencer for the layer-0 feature-map RAM (26x26 words, 18-bit signed).
//  Walks the map in non-overlapping 2x2 windows (stride 2) and drives addr_rd/rd.
//  Takes the four window words returned by the RAM and emits one 2x2 max-pooled word
//  per window: 13x13 = 169 outputs, row-major, over a valid/ready stream to layer 1.
// PARAMETERS
//  DW      18  data width, two's-complement signed
//  AW      10  RAM address width
//  MAP_W   26  input map width = height (even)
//  OAW      8  output index width (must cover (MAP_W/2)^2-1 = 168)
//  RELU_EN  0  1: clamp negative pooled result to 0 before output
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        reset, synchronous, active-low
//  start      in   1        1-cycle pulse: map fully written, begin scan
//  busy       out  1        high from the cycle after accepted start until done
//  done       out  1        1-cycle pulse after the last output is accepted
//  rd         out  1        RAM read strobe; win[] sampled only when rd=1
//  addr_rd    out  AW       window bottom-right address
//  win        in   DW x4    [0]=addr-27 TL, [1]=addr-26 TR, [2]=addr-1 BL, [3]=addr BR; combinational, same cycle
//  pool_dout  out  DW       pooled value
//  pool_idx   out  OAW      output index r*13+c, 0..168
//  pool_vld   out  1        output valid
//  pool_rdy   in   1        downstream ready; transfer = pool_vld & pool_rdy
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE; busy=0, done=0, rd=0, addr_rd=0,
//    pool_vld=0, pool_dout=0, pool_idx=0. Valid mid-scan; the partial frame is abandoned.
//  FSM: IDLE -> SCAN on start; SCAN -> DRAIN after the window at addr 675 issues;
//    DRAIN -> DONE when the output register is empty/transferring; DONE -> IDLE (done=1 here).
//  start is ignored in SCAN/DRAIN/DONE.
//  SCAN, per cycle: issue = !pool_vld | pool_rdy. If issue: rd=1, load output register with
//    max(win[0..3]) and pool_idx; pool_vld=1 next cycle (latency 1 from rd to pool_vld).
//    If !issue: rd=0, addr_rd and counters hold, output register holds.
//  Address walk: first addr_rd=27; per window +2; after col 12, +28 (next even row pair).
//    Last window addr=675. row/col counters 0..12 track the window; no multiplier in the address path.
//  Max: signed compare, 18-bit; a tie selects either (value-identical). RELU_EN=1: result<0 -> 0.
//  pool_vld drops the cycle after a transfer unless a new window issues in the same cycle.
//  Back-to-back: with pool_rdy=1, one output/cycle; 169 outputs in 169 cycles after first rd.
//  busy is high in SCAN and DRAIN only. Asserting start in the DONE cycle is ignored;
//    it must come at IDLE.
//  The address is never driven outside 27..675 while rd=1.
// STRUCTURE
//  Package cnn_pkg: DW, AW, MAP_W, POOL_W (=MAP_W/2), state enum {IDLE,SCAN,DRAIN,DONE}.
//  Sub-module l0_max4: combinational 4-input signed max (two-level compare tree), DW param.
// TESTING
//  1 Ramp map ram[i]=i, pool_rdy=1 -> idx0=27, idx1=29, idx12=51, idx168=675;
//    169 outputs, done 1 cycle after the last.
//  2 All-negative map (-1000-i), RELU_EN=0 -> idx0=-1000; RELU_EN=1 -> all outputs 0.
//  3 Window with max in each of TL/TR/BL/BR positions (value 0x1FFFF, others -5)
//    -> 0x1FFFF every time; mix of 0x20000 (min) and 0 -> 0.
//  4 Random pool_rdy (50%) -> no lost/duplicated idx, pool_dout stable while vld&!rdy,
//    rd=0 during stall.
//  5 start pulsed during SCAN; rst_n low at output 80 -> second start ignored;
//    after reset all outputs 0, new start restarts at idx0/addr 27.
//  6 Two frames back-to-back (start at IDLE right after done) -> both 169-word frames bit-exact.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared widths, map geometry and sequencer states for the layer-0 pool reader
package cnn_pkg;
  localparam int DW = 18;
  localparam int AW = 10;
  localparam int MAP_W = 26;
  localparam int POOL_W = MAP_W / 2;
  localparam int OAW = 8;
  localparam int FIRST_ADDR = MAP_W + 1;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_e;
endpackage

// File: rtl/l0_pool_rd_if.sv
// l0_pool_rd_if: RAM window read port plus pooled output stream
interface l0_pool_rd_if;
  import cnn_pkg::*;
  logic rd;
  logic [AW-1:0] addr_rd;
  logic [3:0][DW-1:0] win;
  logic [DW-1:0] pool_dout;
  logic [OAW-1:0] pool_idx;
  logic pool_vld;
  logic pool_rdy;
  modport master(output rd, addr_rd, pool_dout, pool_idx, pool_vld, input win, pool_rdy);
  modport slave(input rd, addr_rd, pool_dout, pool_idx, pool_vld, output win, pool_rdy);
endinterface

// File: rtl/l0_max4.sv
// l0_max4: combinational signed maximum of four words via a two-level compare tree
module l0_max4 #(parameter int DW = 18) (
  input  logic [3:0][DW-1:0] in_i,
  output logic [DW-1:0]      max_o
);
  logic [DW-1:0] m01, m23;
  always_comb begin
    m01 = $signed(in_i[0]) > $signed(in_i[1]) ? in_i[0] : in_i[1];
    m23 = $signed(in_i[2]) > $signed(in_i[3]) ? in_i[2] : in_i[3];
    max_o = $signed(m01) > $signed(m23) ? m01 : m23;
  end
endmodule

// File: rtl/l0_pool_rd.sv
// l0_pool_rd: walks the layer-0 map in 2x2 stride-2 windows and streams max-pooled words
module l0_pool_rd import cnn_pkg::*; #(parameter bit RELU_EN = 1'b0) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
  l0_pool_rd_if.master pool_if
);
  state_e state_q, state_d;
  logic [3:0] row_q, row_d, col_q, col_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [OAW-1:0] widx_q, widx_d, idx_q, idx_d;
  logic [DW-1:0] dout_q, dout_d, max_w, pooled;
  logic vld_q, vld_d, issue, last_col, last_win;
  l0_max4 #(.DW(DW)) u_max4 (.in_i(pool_if.win), .max_o(max_w));
  always_comb begin
    issue = !vld_q | pool_if.pool_rdy;
    last_col = col_q == 4'(POOL_W - 1);
    last_win = last_col && row_q == 4'(POOL_W - 1);
    pooled = (RELU_EN && max_w[DW-1]) ? '0 : max_w;
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    addr_d = addr_q;
    widx_d = widx_q;
    idx_d = idx_q;
    dout_d = dout_q;
    vld_d = vld_q & !pool_if.pool_rdy;
    pool_if.rd = 1'b0;
    if (state_q == IDLE && start_i) begin
      state_d = SCAN;
      row_d = '0;
      col_d = '0;
      widx_d = '0;
      addr_d = AW'(FIRST_ADDR);
    end
    if (state_q == SCAN && issue) begin
      pool_if.rd = 1'b1;
      vld_d = 1'b1;
      dout_d = pooled;
      idx_d = widx_q;
      widx_d = widx_q + 1'b1;
      col_d = last_col ? '0 : col_q + 1'b1;
      row_d = last_col ? row_q + 1'b1 : row_q;
      // wrapping past the last column skips the odd row to reach the next row pair
      addr_d = last_win ? addr_q : addr_q + (last_col ? AW'(MAP_W + 2) : AW'(2));
      state_d = last_win ? DRAIN : SCAN;
    end
    if (state_q == DRAIN && issue) state_d = DONE;
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q <= '0;
      col_q <= '0;
      addr_q <= '0;
      widx_q <= '0;
      idx_q <= '0;
      dout_q <= '0;
      vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      addr_q <= addr_d;
      widx_q <= widx_d;
      idx_q <= idx_d;
      dout_q <= dout_d;
      vld_q <= vld_d;
    end
  end
  assign busy_o = state_q == SCAN || state_q == DRAIN;
  assign done_o = state_q == DONE;
  assign pool_if.addr_rd = addr_q;
  assign pool_if.pool_dout = dout_q;
  assign pool_if.pool_idx = idx_q;
  assign pool_if.pool_vld = vld_q;
endmodule

// File: tb/tb_l0_pool_rd.sv
// tb_l0_pool_rd: scoreboard bench driving a RAM model into plain and ReLU pool readers
module tb_l0_pool_rd;
  import cnn_pkg::*;
  typedef struct {int idx; int val;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic rdy = 1'b1;
  logic rnd = 1'b0;
  logic busy0, done0, busy1, done1;
  logic signed [DW-1:0] mem [MAP_W*MAP_W];
  logic signed [31:0] got0 [169];
  logic signed [31:0] got1 [169];
  exp_t q0[$];
  exp_t q1[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int n_out0 = 0, last_t = 0, first_rd = 0, first_addr = 0, done_t = 0, done_cnt = 0;
  bit need_first = 1'b0, stall_prev = 1'b0;
  logic [DW-1:0] prev_dout;
  logic [OAW-1:0] prev_idx;
  l0_pool_rd_if if0();
  l0_pool_rd_if if1();
  l0_pool_rd #(.RELU_EN(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .start_i(start), .busy_o(busy0), .done_o(done0), .pool_if(if0.master));
  l0_pool_rd #(.RELU_EN(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .start_i(start), .busy_o(busy1), .done_o(done1), .pool_if(if1.master));
  assign if0.pool_rdy = rdy;
  assign if1.pool_rdy = rdy;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc++;
    #1 rdy = rnd ? 1'($urandom % 2) : 1'b1;
  end
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic logic [3:0][DW-1:0] fetch(input int a);
    if (a < MAP_W + 1 || a > MAP_W * MAP_W - 1) return '0;
    return {mem[a], mem[a-1], mem[a-MAP_W], mem[a-MAP_W-1]};
  endfunction
  // RAM model: window words follow the registered address, settled well before the next edge
  always @(negedge clk) begin
    if0.win = fetch(int'(if0.addr_rd));
    if1.win = fetch(int'(if1.addr_rd));
  end
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (if0.pool_vld && rdy) begin
        if (q0.size() == 0) chk("extra_out0", 1, 0);
        else begin
          e = q0.pop_front();
          chk("idx0", 32'(if0.pool_idx), e.idx);
          chk("dout0", 32'($signed(if0.pool_dout)), e.val);
        end
        if (if0.pool_idx < 169) got0[if0.pool_idx] = 32'($signed(if0.pool_dout));
        n_out0++;
        last_t = cyc;
      end
      if (if1.pool_vld && rdy) begin
        if (q1.size() == 0) chk("extra_out1", 1, 0);
        else begin
          e = q1.pop_front();
          chk("idx1", 32'(if1.pool_idx), e.idx);
          chk("dout1", 32'($signed(if1.pool_dout)), e.val);
        end
        if (if1.pool_idx < 169) got1[if1.pool_idx] = 32'($signed(if1.pool_dout));
      end
      if (stall_prev) begin
        chk("hold_dout", 32'(if0.pool_dout), 32'(prev_dout));
        chk("hold_idx", 32'(if0.pool_idx), 32'(prev_idx));
      end
      if (if0.pool_vld && !rdy) chk("stall_rd", 32'(if0.rd), 0);
      stall_prev = if0.pool_vld && !rdy;
      prev_dout = if0.pool_dout;
      prev_idx = if0.pool_idx;
      if (if0.rd && need_first) begin
        first_rd = cyc;
        first_addr = int'(if0.addr_rd);
        need_first = 1'b0;
      end
      if (done0) begin
        done_t = cyc;
        done_cnt++;
      end
    end else stall_prev = 1'b0;
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push_frame();
    for (int k = 0; k < 169; k++) begin
      int a;
      logic signed [DW-1:0] m;
      a = (2 * (k / POOL_W) + 1) * MAP_W + 2 * (k % POOL_W) + 1;
      m = mem[a];
      if (mem[a-1] > m) m = mem[a-1];
      if (mem[a-MAP_W] > m) m = mem[a-MAP_W];
      if (mem[a-MAP_W-1] > m) m = mem[a-MAP_W-1];
      q0.push_back('{k, int'(m)});
      q1.push_back('{k, m < 0 ? 0 : int'(m)});
    end
  endtask
  task automatic wait_done();
    int d = done_cnt;
    int b = 0;
    while (done_cnt == d && b < 5000) begin
      tick();
      b++;
    end
    if (done_cnt == d) chk("done_timeout", 0, 1);
  endtask
  task automatic pulse_start();
    need_first = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic frame(input bit full_rate);
    push_frame();
    pulse_start();
    wait_done();
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    chk("done_lat", done_t, last_t + 1);
    chk("first_addr", first_addr, FIRST_ADDR);
    chk("busy_end", 32'(busy0), 0);
    if (full_rate) chk("rate", last_t - first_rd, 169);
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy0), 0);
    chk({tag, "_done"}, 32'(done0), 0);
    chk({tag, "_rd"}, 32'(if0.rd), 0);
    chk({tag, "_addr"}, 32'(if0.addr_rd), 0);
    chk({tag, "_vld"}, 32'(if0.pool_vld), 0);
    chk({tag, "_dout"}, 32'(if0.pool_dout), 0);
    chk({tag, "_idx"}, 32'(if0.pool_idx), 0);
  endtask
  initial begin
    tick(3);
    check_reset("rst");
    rst_n = 1'b1;
    tick(2);
    for (int i = 0; i < MAP_W * MAP_W; i++) mem[i] = DW'(i);
    frame(1'b1);
    chk("ramp_idx0", got0[0], 27);
    chk("ramp_idx1", got0[1], 29);
    chk("ramp_idx12", got0[12], 51);
    chk("ramp_idx168", got0[168], 675);
    for (int i = 0; i < MAP_W * MAP_W; i++) mem[i] = DW'(-1000 - i);
    frame(1'b1);
    chk("neg_idx0", got0[0], -1000);
    chk("relu_idx0", got1[0], 0);
    chk("relu_idx168", got1[168], 0);
    for (int i = 0; i < MAP_W * MAP_W; i++) mem[i] = DW'(-5);
    mem[0] = 18'h1FFFF;
    mem[3] = 18'h1FFFF;
    mem[30] = 18'h1FFFF;
    mem[33] = 18'h1FFFF;
    mem[8] = 18'h20000;
    mem[9] = 18'h20000;
    mem[34] = 18'h20000;
    mem[35] = 18'h0;
    mem[10] = 18'h0;
    mem[11] = 18'h20000;
    mem[36] = 18'h20000;
    mem[37] = 18'h20000;
    frame(1'b1);
    chk("max_tl", got0[0], 131071);
    chk("max_tr", got0[1], 131071);
    chk("max_bl", got0[2], 131071);
    chk("max_br", got0[3], 131071);
    chk("min_mix_br", got0[4], 0);
    chk("min_mix_tl", got0[5], 0);
    for (int i = 0; i < MAP_W * MAP_W; i++) mem[i] = DW'(i);
    rnd = 1'b1;
    frame(1'b0);
    rnd = 1'b0;
    tick(2);
    push_frame();
    pulse_start();
    begin
      int b = 0;
      while (n_out0 % 169 < 10 && b < 500) begin
        tick();
        b++;
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_mid", 32'(busy0), 1);
      b = 0;
      while (n_out0 % 169 < 80 && b < 500) begin
        tick();
        b++;
      end
      chk("reach_80", n_out0 % 169, 80);
    end
    rst_n = 1'b0;
    tick(2);
    check_reset("midrst");
    q0.delete();
    q1.delete();
    rst_n = 1'b1;
    n_out0 = 0;
    tick();
    frame(1'b1);
    chk("restart_idx0", got0[0], 27);
    for (int i = 0; i < MAP_W * MAP_W; i++) mem[i] = DW'($urandom);
    push_frame();
    push_frame();
    pulse_start();
    wait_done();
    chk("b2b_first_left", q0.size(), 169);
    pulse_start();
    wait_done();
    chk("b2b_q0_empty", q0.size(), 0);
    chk("b2b_q1_empty", q1.size(), 0);
    chk("b2b_addr", first_addr, FIRST_ADDR);
    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
